multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for a memory ready before trapping.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_rdata_op  input  7  opcode field [6:0] of the instruction-memory read data.
REQ-005 imem_ready  input  1  instruction memory has data for the current request.
REQ-006 dmem_ready  input  1  data memory has completed the current access.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 dmem_req / dmem_we  output  1 each  data access request; write enable (store).
REQ-009 alu_op  output  2  to ALU control: 00 add, 01 subtract, 10 funct-decoded.
REQ-010 alu_src_b  output  1  0 register operand, 1 immediate.
REQ-011 ir_write / pc_write / pc_cond_write  output  1 each  IR load, unconditional PC+4 update, branch PC update (gated by zero externally).
REQ-012 reg_write / mem_to_reg  output  1 each  register-file write; write-back source is load data.
REQ-013 trap / trap_cause  output  1 / 2  sticky trap; cause 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
REQ-014 instret  output  32  retired-instruction count.

Function
REQ-015 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs are Moore-decoded from state plus latched opcode, except ir_write/pc_write, which qualify with imem_ready.
REQ-016 FETCH: imem_req=1, alu_op=00; on imem_ready, ir_write=1, pc_write=1, opcode latched, next DECODE; otherwise stay.
REQ-017 DECODE: one cycle; opcode in {0000011 LOAD, 0100011 STORE, 0110011 OP, 0010011 OP-IMM, 1100011 BRANCH} -> EXEC; any other value -> TRAP with cause 01.
REQ-018 EXEC: OP -> alu_op=10, alu_src_b=0, next WB; OP-IMM -> alu_op=10, alu_src_b=1, next WB; LOAD/STORE -> alu_op=00, alu_src_b=1, next MEM; BRANCH -> alu_op=01, alu_src_b=0, pc_cond_write=1, next FETCH.
REQ-019 MEM: dmem_req=1, dmem_we=1 only for STORE; on dmem_ready, LOAD -> WB, STORE -> FETCH; otherwise stay.
REQ-020 WB: reg_write=1, mem_to_reg=1 only for LOAD; next FETCH.
REQ-021 Zero-wait latency (ready in request cycle): BRANCH 3, OP/OP-IMM/STORE 4, LOAD 5 cycles.
REQ-022 instret SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB; wraps from 0xFFFFFFFF to 0.
REQ-023 Wait counter clears on entry to FETCH or MEM and increments each cycle ready is low; if it reaches MEM_TIMEOUT with ready still low -> TRAP, cause 10 (FETCH) or 11 (MEM).
REQ-024 Ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally (ready wins).
REQ-025 TRAP: all strobes 0, trap=1, trap_cause held; exit only via reset.
REQ-026 Any strobe other than those listed for a state SHALL be 0; alu_op defaults to 00, alu_src_b to 0.

Reset
REQ-027 reset asserted in any state, including mid-wait, SHALL on the next edge set state FETCH, clear wait counter, opcode register, instret, trap, trap_cause.
REQ-028 While reset is high, all strobe outputs SHALL be 0 regardless of state; first imem_req in the cycle after deassertion.

Structure
REQ-029 Package riscv_ctrl_pkg SHALL hold opcode constants, state enum, alu_op encodings and trap-cause encodings.
REQ-030 Wait/timeout counter SHALL be sub-module mem_wait_timer (inputs clear, busy, ready; output expired); width clog2(MEM_TIMEOUT+1).

Verification
REQ-031 OP opcode 0110011, zero-wait memories -> FETCH,DECODE,EXEC(alu_op=10),WB(reg_write=1), instret 0->1 after 4 cycles.
REQ-032 LOAD with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, WB with mem_to_reg=1, total 8 cycles.
REQ-033 Opcode 1111111 -> TRAP after DECODE, trap_cause=01, all strobes 0 for 20 further cycles, instret unchanged.
REQ-034 imem_ready held low, MEM_TIMEOUT=15 -> trap with cause 10 after 15 wait cycles; ready on 15th cycle instead -> normal DECODE.
REQ-035 reset pulsed during MEM of a STORE -> dmem_req drops during reset, FETCH next cycle, instret=0, no trap.
REQ-036 BRANCH zero-wait -> pc_cond_write=1 with alu_op=01 in EXEC, back to FETCH in cycle 4.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU control codes and trap causes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // True for the five opcodes this controller knows how to sequence.
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_OP) ||
           (op == OPC_OP_IMM) || (op == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for ready. expired fires in the
// cycle the count would reach MEM_TIMEOUT while ready is still low, so a
// ready arriving in that same cycle still completes the access.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Clear on state entry / reset, otherwise count each waiting cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (busy && !ready) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = busy && !ready && (cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style main controller: FETCH/DECODE/EXEC/MEM/WB with a
// sticky TRAP state for illegal opcodes and memory timeouts.
//
// Memory handshake: imem_req/dmem_req are held high for as long as the FSM
// sits in FETCH/MEM; the access completes in the first cycle the matching
// ready is sampled high at the rising edge. Ready while no request is
// outstanding is ignored.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  imem_rdata_op,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_cond_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output state_t      state_dbg
);

  state_t      state, state_next;
  logic [6:0]  opcode_q;
  logic [1:0]  cause_next;
  logic        timer_clear, timer_busy, timer_ready, timer_expired;

  assign timer_busy  = (state == ST_FETCH) || (state == ST_MEM);
  assign timer_ready = (state == ST_FETCH) ? imem_ready : dmem_ready;
  assign timer_clear = reset || (state_next != state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .clear   (timer_clear),
    .busy    (timer_busy),
    .ready   (timer_ready),
    .expired (timer_expired)
  );

  // State, latched opcode, retired count and trap cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      opcode_q   <= '0;
      instret    <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
      if (state == ST_FETCH && imem_ready) begin
        opcode_q <= imem_rdata_op;
      end
      if (state_next == ST_FETCH &&
          (state == ST_EXEC || state == ST_MEM || state == ST_WB)) begin
        instret <= instret + 32'd1;
      end
    end
  end

  // Next-state and Moore outputs; reset forces every strobe low.
  always_comb begin
    state_next    = state;
    cause_next    = trap_cause;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_b     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_cond_write = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    unique case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timer_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_IMEM;
        end
      end
      ST_DECODE: begin
        if (is_legal_op(opcode_q)) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (opcode_q == OPC_OP) begin
          alu_op     = ALU_FUNCT;
          state_next = ST_WB;
        end else if (opcode_q == OPC_OP_IMM) begin
          alu_op     = ALU_FUNCT;
          alu_src_b  = 1'b1;
          state_next = ST_WB;
        end else if (opcode_q == OPC_LOAD || opcode_q == OPC_STORE) begin
          alu_src_b  = 1'b1;
          state_next = ST_MEM;
        end else if (opcode_q == OPC_BRANCH) begin
          alu_op        = ALU_SUB;
          pc_cond_write = 1'b1;
          state_next    = ST_FETCH;
        end else begin
          // Unreachable: DECODE filters illegal opcodes.
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OPC_STORE);
        if (dmem_ready) begin
          state_next = (opcode_q == OPC_LOAD) ? ST_WB : ST_FETCH;
        end else if (timer_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_DMEM;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_q == OPC_LOAD);
        state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_TRAP;
      end
    endcase
    if (reset) begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      alu_op        = ALU_ADD;
      alu_src_b     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_cond_write = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
    end
  end

  assign trap      = (state == ST_TRAP);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction flows, memory wait and
// timeout boundaries, illegal opcode trap and reset recovery.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  // Control word order:
  // {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_cond_write,reg_write,
  //  mem_to_reg,alu_op[1:0],alu_src_b}
  localparam logic [10:0] C_ZERO   = 11'b00000000_00_0;
  localparam logic [10:0] C_F_WAIT = 11'b10000000_00_0;
  localparam logic [10:0] C_F_RDY  = 11'b10011000_00_0;
  localparam logic [10:0] C_EX_OP  = 11'b00000000_10_0;
  localparam logic [10:0] C_EX_OPI = 11'b00000000_10_1;
  localparam logic [10:0] C_EX_MEM = 11'b00000000_00_1;
  localparam logic [10:0] C_EX_BR  = 11'b00000100_01_0;
  localparam logic [10:0] C_MEM_LD = 11'b01000000_00_0;
  localparam logic [10:0] C_MEM_ST = 11'b01100000_00_0;
  localparam logic [10:0] C_WB_OP  = 11'b00000010_00_0;
  localparam logic [10:0] C_WB_LD  = 11'b00000011_00_0;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  imem_rdata_op;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, alu_src_b;
  logic [1:0]  alu_op, trap_cause;
  logic        ir_write, pc_write, pc_cond_write, reg_write, mem_to_reg, trap;
  logic [31:0] instret;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_rdata_op (imem_rdata_op),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .alu_op        (alu_op),
    .alu_src_b     (alu_src_b),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_cond_write (pc_cond_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .instret       (instret),
    .state_dbg     (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [10:0] ctl();
    return {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_cond_write,
            reg_write, mem_to_reg, alu_op, alu_src_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and control word for the current cycle, then advance.
  task automatic cyc(input string tag, input state_t st, input logic [10:0] c);
    #1;
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl()), 32'(c));
    @(posedge clk);
    #1;
  endtask

  // Reset pulse: strobes must be low while reset is high.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk({tag, ".rst_ctl"}, 32'(ctl()), 32'(C_ZERO));
    @(posedge clk);
    #1;
    chk({tag, ".rst_state"}, 32'(state_dbg), 32'(ST_FETCH));
    chk({tag, ".rst_instret"}, instret, 32'd0);
    chk({tag, ".rst_trap"}, 32'(trap), 32'd0);
    chk({tag, ".rst_cause"}, 32'(trap_cause), 32'd0);
    chk({tag, ".rst_ctl2"}, 32'(ctl()), 32'(C_ZERO));
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    imem_rdata_op = 7'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("init");

    // OP, zero-wait: 4 cycles, instret 0 -> 1.
    imem_rdata_op = 7'b0110011;
    imem_ready = 1'b1;
    cyc("op.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("op.d", ST_DECODE, C_ZERO);
    cyc("op.e", ST_EXEC, C_EX_OP);
    chk("op.instret_pre", instret, 32'd0);
    cyc("op.w", ST_WB, C_WB_OP);
    chk("op.instret", instret, 32'd1);

    // LOAD with dmem_ready 3 cycles late: 8 cycles total.
    imem_rdata_op = 7'b0000011;
    imem_ready = 1'b1;
    cyc("ld.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    imem_rdata_op = 7'b1111111;
    cyc("ld.d", ST_DECODE, C_ZERO);
    cyc("ld.e", ST_EXEC, C_EX_MEM);
    for (int i = 0; i < 3; i++) cyc("ld.mwait", ST_MEM, C_MEM_LD);
    dmem_ready = 1'b1;
    cyc("ld.m", ST_MEM, C_MEM_LD);
    dmem_ready = 1'b0;
    cyc("ld.w", ST_WB, C_WB_LD);
    chk("ld.instret", instret, 32'd2);

    // STORE zero-wait: 4 cycles.
    imem_rdata_op = 7'b0100011;
    imem_ready = 1'b1;
    cyc("st.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("st.d", ST_DECODE, C_ZERO);
    cyc("st.e", ST_EXEC, C_EX_MEM);
    dmem_ready = 1'b1;
    cyc("st.m", ST_MEM, C_MEM_ST);
    dmem_ready = 1'b0;
    chk("st.state", 32'(state_dbg), 32'(ST_FETCH));
    chk("st.instret", instret, 32'd3);

    // OP-IMM zero-wait.
    imem_rdata_op = 7'b0010011;
    imem_ready = 1'b1;
    cyc("opi.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("opi.d", ST_DECODE, C_ZERO);
    cyc("opi.e", ST_EXEC, C_EX_OPI);
    cyc("opi.w", ST_WB, C_WB_OP);
    chk("opi.instret", instret, 32'd4);

    // BRANCH zero-wait: back in FETCH at cycle 4.
    imem_rdata_op = 7'b1100011;
    imem_ready = 1'b1;
    cyc("br.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("br.d", ST_DECODE, C_ZERO);
    cyc("br.e", ST_EXEC, C_EX_BR);
    chk("br.state", 32'(state_dbg), 32'(ST_FETCH));
    chk("br.instret", instret, 32'd5);

    // imem ready on the 15th wait cycle: ready wins, no trap.
    for (int i = 0; i < 14; i++) cyc("fw.wait", ST_FETCH, C_F_WAIT);
    imem_ready = 1'b1;
    cyc("fw.f15", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("fw.d", ST_DECODE, C_ZERO);
    cyc("fw.e", ST_EXEC, C_EX_BR);
    chk("fw.trap", 32'(trap), 32'd0);
    chk("fw.instret", instret, 32'd6);

    // imem never ready: trap cause 10 after 15 wait cycles.
    for (int i = 0; i < 15; i++) cyc("ft.wait", ST_FETCH, C_F_WAIT);
    cyc("ft.trap", ST_TRAP, C_ZERO);
    chk("ft.trapflag", 32'(trap), 32'd1);
    chk("ft.cause", 32'(trap_cause), 32'd2);
    chk("ft.instret", instret, 32'd6);
    do_reset("ft");

    // One OP, then illegal opcode: trap cause 01, strobes silent, instret held.
    imem_rdata_op = 7'b0110011;
    imem_ready = 1'b1;
    cyc("il.op_f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("il.op_d", ST_DECODE, C_ZERO);
    cyc("il.op_e", ST_EXEC, C_EX_OP);
    cyc("il.op_w", ST_WB, C_WB_OP);
    imem_rdata_op = 7'b1111111;
    imem_ready = 1'b1;
    cyc("il.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("il.d", ST_DECODE, C_ZERO);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'(i % 2);
      dmem_ready = 1'(i % 3 == 0);
      cyc("il.trap", ST_TRAP, C_ZERO);
    end
    chk("il.cause", 32'(trap_cause), 32'd1);
    chk("il.trapflag", 32'(trap), 32'd1);
    chk("il.instret", instret, 32'd1);
    do_reset("il");

    // LOAD with dmem never ready: trap cause 11 after 15 wait cycles.
    imem_rdata_op = 7'b0000011;
    imem_ready = 1'b1;
    cyc("mt.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("mt.d", ST_DECODE, C_ZERO);
    cyc("mt.e", ST_EXEC, C_EX_MEM);
    for (int i = 0; i < 15; i++) cyc("mt.wait", ST_MEM, C_MEM_LD);
    cyc("mt.trap", ST_TRAP, C_ZERO);
    chk("mt.cause", 32'(trap_cause), 32'd3);
    do_reset("mt");

    // Reset in the middle of a STORE's MEM wait.
    imem_rdata_op = 7'b0110011;
    imem_ready = 1'b1;
    cyc("rs.op_f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("rs.op_d", ST_DECODE, C_ZERO);
    cyc("rs.op_e", ST_EXEC, C_EX_OP);
    cyc("rs.op_w", ST_WB, C_WB_OP);
    chk("rs.instret_pre", instret, 32'd1);
    imem_rdata_op = 7'b0100011;
    imem_ready = 1'b1;
    cyc("rs.f", ST_FETCH, C_F_RDY);
    imem_ready = 1'b0;
    cyc("rs.d", ST_DECODE, C_ZERO);
    cyc("rs.e", ST_EXEC, C_EX_MEM);
    cyc("rs.m1", ST_MEM, C_MEM_ST);
    do_reset("rs");
    #1;
    chk("rs.first_req", 32'(ctl()), 32'(C_F_WAIT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
